ex_result_stage: RTL and testbench
==================================

Name: ex_result_stage

Overview:
- EX/MEM boundary stage directly downstream of the ALU.
- Registers the ALU result and destination info, and holds the architectural N/Z flag register, updated only by SUBS beats.
- Resolves conditional branches against the flags and presents each result to the memory/writeback stage over a valid/ready handshake.
- A 2-entry skid buffer lets the ALU side see a registered ready without losing beats.

Parameters:
- DATA_WIDTH, 36, width of ALU result and data path.
- ALU_OP_WIDTH, 3, width of ALU op code (encodings from alu_defs.vh).
- REG_ADDR_WIDTH, 4, destination register index width.
- PC_WIDTH, 16, branch target width.
- COND_WIDTH, 3, branch condition code width.

Ports:
- i_clk  in  1  clock; the single clock for the block.
- i_rst  in  1  reset; synchronous, active-high.
- i_valid  in  1  upstream beat valid.
- o_ready  out  1  stage can accept a beat.
- i_alu_op  in  ALU_OP_WIDTH  op that produced i_alu_result.
- i_alu_result  in  DATA_WIDTH  ALU result.
- i_zero  in  1  ALU zero flag (meaningful when i_alu_op==ALU_SUBS).
- i_negative  in  1  ALU negative flag (meaningful when i_alu_op==ALU_SUBS).
- i_rd  in  REG_ADDR_WIDTH  destination register.
- i_reg_write  in  1  beat writes i_rd.
- i_is_branch  in  1  beat is a conditional branch.
- i_cond  in  COND_WIDTH  branch condition code.
- i_branch_target  in  PC_WIDTH  branch target address.
- i_flush  in  1  discard all in-flight beats.
- o_valid  out  1  output beat valid.
- i_ready  in  1  downstream accepts.
- o_result  out  DATA_WIDTH  registered ALU result.
- o_rd  out  REG_ADDR_WIDTH  destination register.
- o_reg_write  out  1  write enable; forced 0 for branch beats.
- o_branch_taken  out  1  branch beat resolved taken.
- o_branch_target  out  PC_WIDTH  target; 0 unless o_branch_taken.
- o_flag_z  out  1  architectural Z flag.
- o_flag_n  out  1  architectural N flag.

Behaviour:
- Reset: one clock, synchronous, active-high; state=EMPTY. All outputs 0 except o_ready=1; flags cleared.
- Accept condition: i_valid && o_ready && !i_flush.
- Release condition: o_valid && i_ready.
- Latency: an accepted beat appears on o_* the next cycle when the output register is free.
- o_ready is registered: o_ready = (state != SKID).
- States and transitions:
  - EMPTY: accept -> FULL.
  - FULL: accept && !release -> SKID (beat stored in skid). Release && !accept -> EMPTY. Accept && release -> stay FULL; output reloads with the new beat.
  - SKID: release -> FULL; skid moves to output the same cycle. Inputs are ignored, since o_ready=0.
- Beat order is strictly preserved.
- Flag update:
  - On accept with i_alu_op==ALU_SUBS: o_flag_z<=i_zero and o_flag_n<=i_negative, in the accept cycle.
  - Any other op leaves the flags unchanged.
- Branch resolution is performed at accept time and stored with the beat.
  - Flags used: the pre-update flag register. A SUBS beat cannot be a branch; if i_is_branch && SUBS, the beat is treated as a non-branch.
  - Conditions: 0 AL taken; 1 EQ Z; 2 NE !Z; 3 LT N; 4 GE !N; 5 GT !Z&&!N; 6 LE Z||N; 7 NV never.
  - A branch beat forces o_reg_write=0. o_result is still passed through.
- Flush:
  - Next state is EMPTY; o_valid=0 and the skid is invalidated.
  - An input beat presented in the flush cycle is dropped and causes no flag update.
  - Flags updated by previously accepted beats remain.
  - A flush coincident with a release counts the released beat as consumed.
- Output stability: while o_valid && !i_ready, every o_* beat field holds.
- Reset mid-operation: the same effect as flush, plus the flags are cleared.
- Widths: no arithmetic is performed here; all data is passed through bit-exact.

Decomposition:
- Shared package/header (alongside alu_defs.vh):
  - Condition code constants COND_AL..COND_NV.
  - State encodings ST_EMPTY, ST_FULL, ST_SKID.
  - The ALU_* op defines are reused unchanged.
- One natural sub-module: branch_cond_eval, combinational, taking (cond, z, n) and producing taken.
- The skid buffer stays inline.

Test Plan:
- Reset then single beat: ADD result 36'h0_0000_0005, rd=3, reg_write=1, i_ready=1 -> next cycle o_valid=1, o_result=5, o_rd=3; flags remain 0.
- SUBS flags: beat SUBS with result 0, i_zero=1 -> o_flag_z=1, o_flag_n=0. Then SUBS with result 36'hF_FFFF_FFFF, i_negative=1 -> Z=0, N=1.
- Branch resolution: set Z=1, then branch cond=EQ, target 16'h0040 -> o_branch_taken=1, target=16'h0040, o_reg_write=0. Cond=NE -> taken=0, target=0.
- Backpressure/skid: i_ready=0 with 3 back-to-back beats A,B,C -> A held on output, B in skid, o_ready=0, C not accepted. Raise i_ready -> A, B, C emerge in order; no loss or duplication.
- Flush: state SKID, assert i_flush with i_valid beat SUBS (i_zero=1) -> next cycle o_valid=0, o_ready=1, flags unchanged.
- Reset mid-traffic: i_rst during SKID -> next cycle all outputs 0, o_ready=1, flags 0.

Source files
------------

// File: rtl/ex_result_stage_pkg.sv
// ex_result_stage_pkg
//   Shared definitions for the EX/MEM result stage: data path widths, ALU op
//   encodings, branch condition codes, skid FSM states and the registered
//   beat record that travels through the output/skid registers.
package ex_result_stage_pkg;

  localparam int DATA_WIDTH     = 36;
  localparam int ALU_OP_WIDTH   = 3;
  localparam int REG_ADDR_WIDTH = 4;
  localparam int PC_WIDTH       = 16;
  localparam int COND_WIDTH     = 3;

  typedef logic [ALU_OP_WIDTH-1:0] alu_op_t;

  // ALU op encodings, identical to the values in alu_defs.vh.
  localparam alu_op_t ALU_ADD  = 3'd0;
  localparam alu_op_t ALU_SUB  = 3'd1;
  localparam alu_op_t ALU_AND  = 3'd2;
  localparam alu_op_t ALU_OR   = 3'd3;
  localparam alu_op_t ALU_XOR  = 3'd4;
  localparam alu_op_t ALU_SHL  = 3'd5;
  localparam alu_op_t ALU_SHR  = 3'd6;
  localparam alu_op_t ALU_SUBS = 3'd7;

  typedef enum logic [COND_WIDTH-1:0] {
    COND_AL = 3'd0,
    COND_EQ = 3'd1,
    COND_NE = 3'd2,
    COND_LT = 3'd3,
    COND_GE = 3'd4,
    COND_GT = 3'd5,
    COND_LE = 3'd6,
    COND_NV = 3'd7
  } cond_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  // One resolved beat as held in the output register or the skid register.
  typedef struct packed {
    logic [DATA_WIDTH-1:0]     result;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic                      reg_write;
    logic                      branch_taken;
    logic [PC_WIDTH-1:0]       branch_target;
  } beat_t;

endpackage

// File: rtl/ex_result_stage_if.sv
// ex_result_stage_if
//   Bundles the ALU-side input beat, the flush, the downstream handshake and
//   the stage outputs.
//   master : the environment (ALU + memory/writeback stage) view.
//   slave  : the ex_result_stage view.
interface ex_result_stage_if;
  import ex_result_stage_pkg::*;

  // ALU side
  logic                      i_valid;
  logic                      o_ready;
  logic [ALU_OP_WIDTH-1:0]   i_alu_op;
  logic [DATA_WIDTH-1:0]     i_alu_result;
  logic                      i_zero;
  logic                      i_negative;
  logic [REG_ADDR_WIDTH-1:0] i_rd;
  logic                      i_reg_write;
  logic                      i_is_branch;
  logic [COND_WIDTH-1:0]     i_cond;
  logic [PC_WIDTH-1:0]       i_branch_target;
  logic                      i_flush;
  // memory/writeback side
  logic                      o_valid;
  logic                      i_ready;
  logic [DATA_WIDTH-1:0]     o_result;
  logic [REG_ADDR_WIDTH-1:0] o_rd;
  logic                      o_reg_write;
  logic                      o_branch_taken;
  logic [PC_WIDTH-1:0]       o_branch_target;
  logic                      o_flag_z;
  logic                      o_flag_n;

  modport master (
    output i_valid, i_alu_op, i_alu_result, i_zero, i_negative, i_rd,
           i_reg_write, i_is_branch, i_cond, i_branch_target, i_flush, i_ready,
    input  o_ready, o_valid, o_result, o_rd, o_reg_write, o_branch_taken,
           o_branch_target, o_flag_z, o_flag_n
  );

  modport slave (
    input  i_valid, i_alu_op, i_alu_result, i_zero, i_negative, i_rd,
           i_reg_write, i_is_branch, i_cond, i_branch_target, i_flush, i_ready,
    output o_ready, o_valid, o_result, o_rd, o_reg_write, o_branch_taken,
           o_branch_target, o_flag_z, o_flag_n
  );

endinterface

// File: rtl/ex_result_stage_branch_cond_eval.sv
// branch_cond_eval
//   Combinational condition evaluator: decides whether a branch with
//   condition code cond is taken given the Z and N flags.
//   cond  : condition code (COND_AL..COND_NV)
//   z, n  : flag values to test
//   taken : condition holds
module branch_cond_eval
  import ex_result_stage_pkg::*;
(
  input  cond_t cond,
  input  logic  z,
  input  logic  n,
  output logic  taken
);

  always_comb begin
    // NOTE: default assignment first so no path through the case leaves
    // taken unassigned, which would otherwise infer a latch.
    taken = 1'b0;
    case (cond)
      COND_AL: taken = 1'b1;
      COND_EQ: taken = z;
      COND_NE: taken = !z;
      COND_LT: taken = n;
      COND_GE: taken = !n;
      COND_GT: taken = !z && !n;
      COND_LE: taken = z || n;
      COND_NV: taken = 1'b0;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_result_stage.sv
// ex_result_stage
//   EX/MEM boundary stage behind the ALU. Registers each accepted beat,
//   resolves conditional branches against the architectural N/Z flags (which
//   only SUBS beats update) and hands beats downstream over valid/ready.
//   A two-entry output+skid buffer keeps o_ready a pure register.
//   i_clk : clock
//   i_rst : synchronous active-high reset
//   bus   : ex_result_stage_if.slave (input beat, flush, output beat, flags)
module ex_result_stage
  import ex_result_stage_pkg::*;
(
  input logic            i_clk,
  input logic            i_rst,
  ex_result_stage_if.slave bus
);

  state_t state;
  beat_t  out_q;
  beat_t  skid_q;
  beat_t  in_beat;
  logic   valid_q;
  logic   ready_q;
  logic   flag_z_q;
  logic   flag_n_q;
  logic   is_subs;
  logic   is_branch;
  logic   cond_taken;
  logic   accept;
  logic   rel;

  assign is_subs = (bus.i_alu_op == ALU_SUBS);
  // A SUBS beat can never be a branch; the branch bit is ignored for it.
  assign is_branch = bus.i_is_branch && !is_subs;
  assign accept = bus.i_valid && ready_q && !bus.i_flush;
  assign rel    = valid_q && bus.i_ready;

  // Branches resolve against the flags as they stand before this beat.
  branch_cond_eval u_cond (
    .cond  (cond_t'(bus.i_cond)),
    .z     (flag_z_q),
    .n     (flag_n_q),
    .taken (cond_taken)
  );

  always_comb begin
    in_beat               = '0;
    in_beat.result        = bus.i_alu_result;
    in_beat.rd            = bus.i_rd;
    in_beat.reg_write     = bus.i_reg_write && !is_branch;
    in_beat.branch_taken  = is_branch && cond_taken;
    in_beat.branch_target = (is_branch && cond_taken) ? bus.i_branch_target : '0;
  end

  always_ff @(posedge i_clk) begin
    // NOTE: every register here is sequential state, so non-blocking
    // assignments only; the ordering of statements then cannot change results.
    if (i_rst) begin
      state    <= ST_EMPTY;
      out_q    <= '0;
      // NOTE: the skid payload is cleared as well; it is never visible while
      // invalid, but a clean value keeps reset state fully deterministic.
      skid_q   <= '0;
      valid_q  <= 1'b0;
      ready_q  <= 1'b1;
      flag_z_q <= 1'b0;
      flag_n_q <= 1'b0;
    end else begin
      if (accept && is_subs) begin
        flag_z_q <= bus.i_zero;
        flag_n_q <= bus.i_negative;
      end

      if (bus.i_flush) begin
        // Drops output and skid; a beat released this cycle is consumed.
        state   <= ST_EMPTY;
        valid_q <= 1'b0;
        ready_q <= 1'b1;
      end else begin
        case (state)
          ST_EMPTY: begin
            if (accept) begin
              out_q   <= in_beat;
              valid_q <= 1'b1;
              state   <= ST_FULL;
            end
          end
          ST_FULL: begin
            if (accept && rel) begin
              out_q <= in_beat;
            end else if (accept) begin
              skid_q  <= in_beat;
              ready_q <= 1'b0;
              state   <= ST_SKID;
            end else if (rel) begin
              valid_q <= 1'b0;
              state   <= ST_EMPTY;
            end
          end
          ST_SKID: begin
            // o_ready is low here, so no new beat can arrive.
            if (rel) begin
              out_q   <= skid_q;
              ready_q <= 1'b1;
              state   <= ST_FULL;
            end
          end
          default: begin
            state   <= ST_EMPTY;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
          end
        endcase
      end
    end
  end

  assign bus.o_ready         = ready_q;
  assign bus.o_valid         = valid_q;
  assign bus.o_result        = out_q.result;
  assign bus.o_rd            = out_q.rd;
  assign bus.o_reg_write     = out_q.reg_write;
  assign bus.o_branch_taken  = out_q.branch_taken;
  assign bus.o_branch_target = out_q.branch_target;
  assign bus.o_flag_z        = flag_z_q;
  assign bus.o_flag_n        = flag_n_q;

endmodule

// File: tb/tb_ex_result_stage.sv
// tb_ex_result_stage
//   Self-checking bench for ex_result_stage: a vector table for single beats
//   and branch conditions, hand-written skid/flush/reset sequences, and a
//   randomized run against a queue-based reference model.
module tb_ex_result_stage;
  import ex_result_stage_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ex_result_stage_if bus ();

  ex_result_stage dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    bus.i_valid         = 1'b0;
    bus.i_alu_op        = '0;
    bus.i_alu_result    = '0;
    bus.i_zero          = 1'b0;
    bus.i_negative      = 1'b0;
    bus.i_rd            = '0;
    bus.i_reg_write     = 1'b0;
    bus.i_is_branch     = 1'b0;
    bus.i_cond          = '0;
    bus.i_branch_target = '0;
    bus.i_flush         = 1'b0;
  endtask

  task automatic drive_beat(input logic [2:0] op, input logic [35:0] res, input logic z,
                            input logic n, input logic [3:0] rd, input logic wr,
                            input logic br, input logic [2:0] cond, input logic [15:0] tgt);
    bus.i_valid         = 1'b1;
    bus.i_alu_op        = op;
    bus.i_alu_result    = res;
    bus.i_zero          = z;
    bus.i_negative      = n;
    bus.i_rd            = rd;
    bus.i_reg_write     = wr;
    bus.i_is_branch     = br;
    bus.i_cond          = cond;
    bus.i_branch_target = tgt;
  endtask

  // Single-beat vectors with their expected outputs one cycle later.
  typedef struct {
    logic [2:0]  op;
    logic [35:0] res;
    logic        z, n;
    logic [3:0]  rd;
    logic        wr, br;
    logic [2:0]  cond;
    logic [15:0] tgt;
    logic        exp_wr, exp_taken;
    logic [15:0] exp_tgt;
    logic        exp_fz, exp_fn;
  } vec_t;

  vec_t vecs[$];

  // Reference model state for the random phase.
  typedef struct {
    logic [35:0] res;
    logic [3:0]  rd;
    logic        wr, taken;
    logic [15:0] tgt;
  } exp_t;

  exp_t model_q[$];
  logic m_z, m_n;

  function automatic logic cond_holds(input logic [2:0] c, input logic z, input logic n);
    case (c)
      3'd0:    return 1'b1;
      3'd1:    return z;
      3'd2:    return !z;
      3'd3:    return n;
      3'd4:    return !n;
      3'd5:    return !z && !n;
      3'd6:    return z || n;
      default: return 1'b0;
    endcase
  endfunction

  task automatic check_out(input string tag, input logic [35:0] res, input logic [3:0] rd,
                           input logic wr, input logic taken, input logic [15:0] tgt);
    check({tag, ".o_valid"}, 64'(bus.o_valid), 64'd1);
    check({tag, ".o_result"}, 64'(bus.o_result), 64'(res));
    check({tag, ".o_rd"}, 64'(bus.o_rd), 64'(rd));
    check({tag, ".o_reg_write"}, 64'(bus.o_reg_write), 64'(wr));
    check({tag, ".o_branch_taken"}, 64'(bus.o_branch_taken), 64'(taken));
    check({tag, ".o_branch_target"}, 64'(bus.o_branch_target), 64'(tgt));
  endtask

  initial begin
    logic [63:0] rnd;
    logic        r_rst, r_flush, r_valid, r_ready, r_z, r_n, r_wr, r_br;
    logic [2:0]  r_op, r_cond;
    logic [3:0]  r_rd;
    logic [15:0] r_tgt;
    logic        is_br, m_ready, acc, rel;
    exp_t        e;

    //             op        res              z  n  rd wr br cond tgt       ewr et etgt     fz fn
    vecs.push_back('{ALU_ADD,  36'h0_0000_0005, 0, 0, 3, 1, 0, 0, 16'h0000, 1, 0, 16'h0000, 0, 0});
    vecs.push_back('{ALU_SUBS, 36'h0_0000_0000, 1, 0, 1, 1, 0, 0, 16'h0000, 1, 0, 16'h0000, 1, 0});
    vecs.push_back('{ALU_SUBS, 36'hF_FFFF_FFFF, 0, 1, 2, 1, 0, 0, 16'h0000, 1, 0, 16'h0000, 0, 1});
    vecs.push_back('{ALU_SUBS, 36'h0_0000_0000, 1, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 0});
    vecs.push_back('{ALU_ADD,  36'h0_0000_0123, 0, 0, 5, 1, 1, 1, 16'h0040, 0, 1, 16'h0040, 1, 0});
    vecs.push_back('{ALU_ADD,  36'h0_0000_0124, 0, 0, 5, 1, 1, 2, 16'h0040, 0, 0, 16'h0000, 1, 0});
    vecs.push_back('{ALU_SUB,  36'h8_0000_0001, 1, 1, 6, 1, 1, 3, 16'h0100, 0, 0, 16'h0000, 1, 0});
    vecs.push_back('{ALU_AND,  36'h0_1234_5678, 0, 0, 7, 0, 1, 4, 16'h0200, 0, 1, 16'h0200, 1, 0});
    vecs.push_back('{ALU_OR,   36'h5_5555_5555, 0, 0, 8, 1, 1, 5, 16'h0300, 0, 0, 16'h0000, 1, 0});
    vecs.push_back('{ALU_XOR,  36'hA_AAAA_AAAA, 0, 0, 9, 1, 1, 6, 16'h0400, 0, 1, 16'h0400, 1, 0});
    vecs.push_back('{ALU_SHL,  36'h0_0000_0010, 0, 0, 4, 1, 1, 0, 16'hFFFF, 0, 1, 16'hFFFF, 1, 0});
    vecs.push_back('{ALU_SHR,  36'h0_0000_0020, 0, 0, 4, 1, 1, 7, 16'h0500, 0, 0, 16'h0000, 1, 0});
    vecs.push_back('{ALU_SUBS, 36'hC_0000_0000, 0, 1, 7, 1, 1, 0, 16'h1234, 1, 0, 16'h0000, 0, 1});
    vecs.push_back('{ALU_ADD,  36'h0_0000_0042, 0, 0, 2, 1, 1, 3, 16'h0600, 0, 1, 16'h0600, 0, 1});
    vecs.push_back('{ALU_ADD,  36'h0_0000_0043, 0, 0, 2, 1, 1, 5, 16'h0700, 0, 0, 16'h0000, 0, 1});

    // ---- reset ----
    idle_inputs();
    bus.i_ready = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst.o_valid", 64'(bus.o_valid), 64'd0);
    check("rst.o_ready", 64'(bus.o_ready), 64'd1);
    check("rst.o_result", 64'(bus.o_result), 64'd0);
    check("rst.o_rd", 64'(bus.o_rd), 64'd0);
    check("rst.o_reg_write", 64'(bus.o_reg_write), 64'd0);
    check("rst.o_branch_taken", 64'(bus.o_branch_taken), 64'd0);
    check("rst.o_branch_target", 64'(bus.o_branch_target), 64'd0);
    check("rst.flags", 64'({bus.o_flag_z, bus.o_flag_n}), 64'd0);

    // ---- vector table, back-to-back with i_ready=1 ----
    foreach (vecs[i]) begin
      drive_beat(vecs[i].op, vecs[i].res, vecs[i].z, vecs[i].n, vecs[i].rd, vecs[i].wr,
                 vecs[i].br, vecs[i].cond, vecs[i].tgt);
      @(negedge clk);
      check_out($sformatf("vec%0d", i), vecs[i].res, vecs[i].rd, vecs[i].exp_wr,
                vecs[i].exp_taken, vecs[i].exp_tgt);
      check($sformatf("vec%0d.o_ready", i), 64'(bus.o_ready), 64'd1);
      check($sformatf("vec%0d.flag_z", i), 64'(bus.o_flag_z), 64'(vecs[i].exp_fz));
      check($sformatf("vec%0d.flag_n", i), 64'(bus.o_flag_n), 64'(vecs[i].exp_fn));
    end
    idle_inputs();
    @(negedge clk);
    check("drain.o_valid", 64'(bus.o_valid), 64'd0);

    // ---- backpressure: A, B, C with i_ready=0 ----
    bus.i_ready = 1'b0;
    drive_beat(ALU_ADD, 36'hA_AAAA_0001, 0, 0, 4'd10, 1, 0, 0, 16'h0);
    @(negedge clk);
    check_out("skidA0", 36'hA_AAAA_0001, 4'd10, 1, 0, 16'h0);
    check("skidA0.o_ready", 64'(bus.o_ready), 64'd1);
    drive_beat(ALU_SUB, 36'hB_BBBB_0002, 0, 0, 4'd11, 1, 0, 0, 16'h0);
    @(negedge clk);
    check_out("skidA1", 36'hA_AAAA_0001, 4'd10, 1, 0, 16'h0);
    check("skidA1.o_ready", 64'(bus.o_ready), 64'd0);
    drive_beat(ALU_OR, 36'hC_CCCC_0003, 0, 0, 4'd12, 1, 0, 0, 16'h0);
    @(negedge clk);
    check_out("skidA2", 36'hA_AAAA_0001, 4'd10, 1, 0, 16'h0);
    check("skidA2.o_ready", 64'(bus.o_ready), 64'd0);
    bus.i_ready = 1'b1;
    @(negedge clk);
    check_out("skidB", 36'hB_BBBB_0002, 4'd11, 1, 0, 16'h0);
    check("skidB.o_ready", 64'(bus.o_ready), 64'd1);
    @(negedge clk);
    check_out("skidC", 36'hC_CCCC_0003, 4'd12, 1, 0, 16'h0);
    idle_inputs();
    @(negedge clk);
    check("skid_end.o_valid", 64'(bus.o_valid), 64'd0);
    check("skid_end.o_ready", 64'(bus.o_ready), 64'd1);

    // ---- flush while in SKID with a SUBS beat offered (flags Z=0 N=1) ----
    bus.i_ready = 1'b0;
    drive_beat(ALU_ADD, 36'h1_0000_0001, 0, 0, 4'd1, 1, 0, 0, 16'h0);
    @(negedge clk);
    drive_beat(ALU_ADD, 36'h1_0000_0002, 0, 0, 4'd2, 1, 0, 0, 16'h0);
    @(negedge clk);
    check("flush_pre.o_ready", 64'(bus.o_ready), 64'd0);
    drive_beat(ALU_SUBS, 36'h0, 1, 0, 4'd3, 1, 0, 0, 16'h0);
    bus.i_flush = 1'b1;
    @(negedge clk);
    idle_inputs();
    check("flush.o_valid", 64'(bus.o_valid), 64'd0);
    check("flush.o_ready", 64'(bus.o_ready), 64'd1);
    check("flush.flag_z", 64'(bus.o_flag_z), 64'd0);
    check("flush.flag_n", 64'(bus.o_flag_n), 64'd1);
    bus.i_ready = 1'b1;
    @(negedge clk);
    check("flush_post.o_valid", 64'(bus.o_valid), 64'd0);

    // ---- reset mid-traffic in SKID with flags set ----
    drive_beat(ALU_SUBS, 36'h0, 1, 1, 4'd0, 0, 0, 0, 16'h0);
    @(negedge clk);
    bus.i_ready = 1'b0;
    drive_beat(ALU_ADD, 36'h2_0000_0001, 0, 0, 4'd5, 1, 1, 0, 16'h0077);
    @(negedge clk);
    drive_beat(ALU_ADD, 36'h2_0000_0002, 0, 0, 4'd6, 1, 0, 0, 16'h0);
    @(negedge clk);
    check("rst_mid_pre.o_ready", 64'(bus.o_ready), 64'd0);
    check("rst_mid_pre.flags", 64'({bus.o_flag_z, bus.o_flag_n}), 64'd3);
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid.o_valid", 64'(bus.o_valid), 64'd0);
    check("rst_mid.o_ready", 64'(bus.o_ready), 64'd1);
    check("rst_mid.o_result", 64'(bus.o_result), 64'd0);
    check("rst_mid.o_rd", 64'(bus.o_rd), 64'd0);
    check("rst_mid.o_branch", 64'({bus.o_branch_taken, bus.o_branch_target}), 64'd0);
    check("rst_mid.o_reg_write", 64'(bus.o_reg_write), 64'd0);
    check("rst_mid.flags", 64'({bus.o_flag_z, bus.o_flag_n}), 64'd0);

    // ---- randomized traffic against the reference model ----
    model_q.delete();
    m_z = 1'b0;
    m_n = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      check("rnd.o_ready", 64'(bus.o_ready), 64'(model_q.size() < 2));
      check("rnd.o_valid", 64'(bus.o_valid), 64'(model_q.size() != 0));
      check("rnd.flag_z", 64'(bus.o_flag_z), 64'(m_z));
      check("rnd.flag_n", 64'(bus.o_flag_n), 64'(m_n));
      if (model_q.size() != 0)
        check_out("rnd", model_q[0].res, model_q[0].rd, model_q[0].wr,
                  model_q[0].taken, model_q[0].tgt);

      r_rst   = ($urandom_range(0, 249) == 0);
      r_flush = ($urandom_range(0, 24) == 0);
      r_valid = ($urandom_range(0, 3) != 0);
      r_ready = ($urandom_range(0, 2) != 0);
      r_op    = ($urandom_range(0, 3) == 0) ? ALU_SUBS : 3'($urandom_range(0, 7));
      rnd     = {$urandom(), $urandom()};
      r_z     = 1'($urandom_range(0, 1));
      r_n     = 1'($urandom_range(0, 1));
      r_rd    = 4'($urandom_range(0, 15));
      r_wr    = 1'($urandom_range(0, 1));
      r_br    = 1'($urandom_range(0, 1));
      r_cond  = 3'($urandom_range(0, 7));
      r_tgt   = 16'($urandom_range(0, 65535));

      drive_beat(r_op, rnd[35:0], r_z, r_n, r_rd, r_wr, r_br, r_cond, r_tgt);
      bus.i_valid = r_valid;
      bus.i_flush = r_flush;
      bus.i_ready = r_ready;
      rst         = r_rst;

      if (r_rst) begin
        model_q.delete();
        m_z = 1'b0;
        m_n = 1'b0;
      end else begin
        m_ready = (model_q.size() < 2);
        acc     = r_valid && m_ready && !r_flush;
        rel     = (model_q.size() != 0) && r_ready;
        is_br   = r_br && (r_op != ALU_SUBS);
        e.res   = rnd[35:0];
        e.rd    = r_rd;
        e.wr    = r_wr && !is_br;
        e.taken = is_br && cond_holds(r_cond, m_z, m_n);
        e.tgt   = e.taken ? r_tgt : 16'h0;
        if (rel) void'(model_q.pop_front());
        if (r_flush) model_q.delete();
        else if (acc) model_q.push_back(e);
        if (acc && (r_op == ALU_SUBS)) begin
          m_z = r_z;
          m_n = r_n;
        end
      end
      @(negedge clk);
    end
    rst = 1'b0;
    idle_inputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
